// File: rtl/dump_sequencer.sv
// rtl/dump_sequencer.sv - streams PC, register bank and data memory out over a byte UART
//
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_start, i_abort          begin a full dump (IDLE only), synchronous abort
//   i_tx_done                 UART byte-complete tick
//   i_pc_value                current PC
//   i_bank_reg_data           register-bank read data (one cycle after read)
//   i_mem_data                data-memory read data (one cycle after read)
//   o_rb_addr/_enable/_read_enable            register-bank debug read port
//   o_mem_data_addr/_enable/_read_enable      data-memory debug read port
//   o_tx_data, o_tx_start     byte to send and one-cycle start pulse
//   o_busy, o_done, o_section dump active, completion pulse, section (0 PC, 1 RB, 2 MEM, 3 idle)
module dump_sequencer #(
    parameter int BYTE          = 8,
    parameter int DWORD         = 32,
    parameter int RB_ADDR_SIZE  = 5,
    parameter int MEM_ADDR_SIZE = 5
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_tx_done,
    input  logic [DWORD-1:0]         i_pc_value,
    input  logic [DWORD-1:0]         i_bank_reg_data,
    input  logic [DWORD-1:0]         i_mem_data,
    output logic [RB_ADDR_SIZE-1:0]  o_rb_addr,
    output logic                     o_rb_enable,
    output logic                     o_rb_read_enable,
    output logic [MEM_ADDR_SIZE-1:0] o_mem_data_addr,
    output logic                     o_mem_data_enable,
    output logic                     o_mem_data_read_enable,
    output logic [BYTE-1:0]          o_tx_data,
    output logic                     o_tx_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [1:0]               o_section
);

    localparam int IDX_W          = (RB_ADDR_SIZE > MEM_ADDR_SIZE) ? RB_ADDR_SIZE : MEM_ADDR_SIZE;
    localparam int BYTES_PER_WORD = DWORD / BYTE;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    localparam logic [IDX_W-1:0] RB_LAST   = IDX_W'((1 << RB_ADDR_SIZE) - 1);
    localparam logic [IDX_W-1:0] MEM_LAST  = IDX_W'((1 << MEM_ADDR_SIZE) - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    localparam logic [1:0] SEC_PC   = 2'd0;
    localparam logic [1:0] SEC_RB   = 2'd1;
    localparam logic [1:0] SEC_MEM  = 2'd2;
    localparam logic [1:0] SEC_IDLE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_TX,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [1:0]           sec_q;
    logic [CNT_W-1:0]     byte_cnt_q;
    logic [DWORD-1:0]     shift_q;
    logic [DWORD-1:0]     pc_q;
    logic [RB_ADDR_SIZE-1:0]  rb_addr_q;
    logic [MEM_ADDR_SIZE-1:0] mem_addr_q;

    // The byte under transmission is always the low byte of the shift
    // register; it only moves on an accepted tx_done, so it is stable
    // for the whole of WAIT_TX.
    assign o_tx_data = shift_q[BYTE-1:0];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        o_rb_enable            = 1'b0;
        o_rb_read_enable       = 1'b0;
        o_mem_data_enable      = 1'b0;
        o_mem_data_read_enable = 1'b0;
        o_tx_start             = 1'b0;
        o_done                 = 1'b0;
        o_busy                 = (state_q != ST_IDLE);
        o_section              = (state_q == ST_IDLE || state_q == ST_DONE) ? SEC_IDLE : sec_q;
        // Addresses show the live index only during FETCH, otherwise the
        // value captured at the last FETCH.
        o_rb_addr              = rb_addr_q;
        o_mem_data_addr        = mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (sec_q == SEC_RB) begin
                    o_rb_enable      = 1'b1;
                    o_rb_read_enable = 1'b1;
                    o_rb_addr        = idx_q[RB_ADDR_SIZE-1:0];
                end else if (sec_q == SEC_MEM) begin
                    o_mem_data_enable      = 1'b1;
                    o_mem_data_read_enable = 1'b1;
                    o_mem_data_addr        = idx_q[MEM_ADDR_SIZE-1:0];
                end
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                o_tx_start = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = (byte_cnt_q == LAST_BYTE) ? ST_NEXT : ST_SEND;
                end
            end
            ST_NEXT: begin
                if (sec_q == SEC_MEM && idx_q == MEM_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident tx_done.
        if (i_abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            idx_q      <= '0;
            sec_q      <= SEC_PC;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            pc_q       <= '0;
            rb_addr_q  <= '0;
            mem_addr_q <= '0;
        end else if (i_abort) begin
            idx_q <= '0;
            sec_q <= SEC_PC;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    case (sec_q)
                        SEC_PC:  pc_q       <= i_pc_value;
                        SEC_RB:  rb_addr_q  <= idx_q[RB_ADDR_SIZE-1:0];
                        SEC_MEM: mem_addr_q <= idx_q[MEM_ADDR_SIZE-1:0];
                        default: ;
                    endcase
                end
                ST_LATCH: begin
                    byte_cnt_q <= '0;
                    case (sec_q)
                        SEC_PC:  shift_q <= pc_q;
                        SEC_RB:  shift_q <= i_bank_reg_data;
                        default: shift_q <= i_mem_data;
                    endcase
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        shift_q    <= shift_q >> BYTE;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
                ST_NEXT: begin
                    case (sec_q)
                        SEC_PC: begin
                            sec_q <= SEC_RB;
                            idx_q <= '0;
                        end
                        SEC_RB: begin
                            if (idx_q == RB_LAST) begin
                                sec_q <= SEC_MEM;
                                idx_q <= '0;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                        SEC_MEM: begin
                            // The last MEM word leads to DONE, which clears the index.
                            if (idx_q != MEM_LAST) begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_DONE: begin
                    idx_q <= '0;
                    sec_q <= SEC_PC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dump_sequencer.sv
// tb/tb_dump_sequencer.sv - self-checking bench for dump_sequencer
module tb_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_tx_done = 1'b0;
    logic [31:0] i_pc_value = '0;
    logic [31:0] i_bank_reg_data = '0;
    logic [31:0] i_mem_data = '0;
    logic [4:0]  o_rb_addr;
    logic        o_rb_enable, o_rb_read_enable;
    logic [4:0]  o_mem_data_addr;
    logic        o_mem_data_enable, o_mem_data_read_enable;
    logic [7:0]  o_tx_data;
    logic        o_tx_start, o_busy, o_done;
    logic [1:0]  o_section;

    dump_sequencer dut (
        .i_clock               (clk),
        .i_reset               (rst),
        .i_start               (i_start),
        .i_abort               (i_abort),
        .i_tx_done             (i_tx_done),
        .i_pc_value            (i_pc_value),
        .i_bank_reg_data       (i_bank_reg_data),
        .i_mem_data            (i_mem_data),
        .o_rb_addr             (o_rb_addr),
        .o_rb_enable           (o_rb_enable),
        .o_rb_read_enable      (o_rb_read_enable),
        .o_mem_data_addr       (o_mem_data_addr),
        .o_mem_data_enable     (o_mem_data_enable),
        .o_mem_data_read_enable(o_mem_data_read_enable),
        .o_tx_data             (o_tx_data),
        .o_tx_start            (o_tx_start),
        .o_busy                (o_busy),
        .o_done                (o_done),
        .o_section             (o_section)
    );

    always #5 clk = ~clk;

    // Reference contents and expected byte stream
    logic [31:0] pc_m;
    logic [31:0] rb_m  [32];
    logic [31:0] mem_m [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q  [$];

    int total = 0;
    int passed = 0;

    // Monitor state
    int done_count = 0, rb_reads = 0, mem_reads = 0, read_err = 0;
    int tx_unstable = 0, proto_err = 0, lat_cfg = 10, abort_at = 0, cnt = 0;
    logic [31:0] trace = '0;
    logic [1:0]  last_sec = 2'd3;
    logic [7:0]  cur_byte = '0;
    bit pending = 0, prev_rb_re = 0, prev_mem_re = 0, prev_start = 0, prev_done = 0;
    bit rb_pend = 0, mem_pend = 0;
    logic [4:0] rb_pend_addr = '0, mem_pend_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected stream: PC, RB[0..31], MEM[0..31], each word LSB first.
    function automatic void build_expected();
        exp_q.delete();
        for (int w = 0; w < 65; w++) begin
            logic [31:0] word;
            if (w == 0)       word = pc_m;
            else if (w <= 32) word = rb_m[w-1];
            else              word = mem_m[w-33];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'((word >> (8 * b)) & 32'hFF));
            end
        end
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic int stream_errors(input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_at(i) !== exp_q[i]) e++;
        end
        return e;
    endfunction

    function automatic void randomize_contents();
        pc_m = $urandom;
        for (int k = 0; k < 32; k++) begin
            rb_m[k]  = $urandom;
            mem_m[k] = $urandom;
        end
    endfunction

    // UART responder and port monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0; i_tx_done = 0; i_abort = 0;
                prev_rb_re = 0; prev_mem_re = 0; prev_start = 0; prev_done = 0;
                rb_pend = 0; mem_pend = 0;
            end else begin
                if (i_tx_done) begin
                    i_tx_done = 0;
                    i_abort   = 0;
                end
                if (o_done) begin
                    if (prev_done) proto_err++;
                    done_count++;
                end
                if (o_rb_read_enable) begin
                    if (!o_rb_enable || o_rb_addr !== 5'(rb_reads) || prev_rb_re || o_section != 2'd1)
                        read_err++;
                    rb_pend = 1; rb_pend_addr = o_rb_addr; rb_reads++;
                end else if (o_rb_enable) read_err++;
                if (o_mem_data_read_enable) begin
                    if (!o_mem_data_enable || o_mem_data_addr !== 5'(mem_reads) || prev_mem_re || o_section != 2'd2)
                        read_err++;
                    mem_pend = 1; mem_pend_addr = o_mem_data_addr; mem_reads++;
                end else if (o_mem_data_enable) read_err++;
                if (o_section != last_sec) begin
                    trace    = {trace[29:0], o_section};
                    last_sec = o_section;
                end
                if (o_tx_start) begin
                    if (prev_start || pending) proto_err++;
                    rx_q.push_back(o_tx_data);
                    cur_byte = o_tx_data;
                    pending  = 1;
                    cnt = (lat_cfg == 0) ? int'($urandom_range(12, 1)) : lat_cfg;
                end else if (pending) begin
                    if (o_tx_data !== cur_byte) tx_unstable++;
                    cnt--;
                    if (cnt <= 0) begin
                        i_tx_done = 1;
                        pending   = 0;
                        if (abort_at != 0 && rx_q.size() == abort_at) i_abort = 1;
                    end
                end
                prev_rb_re  = o_rb_read_enable;
                prev_mem_re = o_mem_data_read_enable;
                prev_start  = o_tx_start;
                prev_done   = o_done;
            end
        end
    end

    // Memories with one-cycle read latency; junk on the bus otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rb_pend && !rst) begin
                i_bank_reg_data = rb_m[rb_pend_addr];
                rb_pend = 0;
            end else i_bank_reg_data = $urandom;
            if (mem_pend && !rst) begin
                i_mem_data = mem_m[mem_pend_addr];
                mem_pend = 0;
            end else i_mem_data = $urandom;
        end
    end

    task automatic clear_counters();
        rx_q.delete();
        done_count = 0; rb_reads = 0; mem_reads = 0; read_err = 0;
        tx_unstable = 0; proto_err = 0; trace = '0; last_sec = o_section;
    endtask

    // Pulses i_start and measures cycles to the first o_tx_start; the PC input
    // is scrambled after the FETCH edge so only a FETCH-time sample is correct.
    task automatic start_dump(output int lat, output bit fetch_ok);
        lat = 0;
        fetch_ok = 0;
        i_pc_value = pc_m;
        @(negedge clk); #1;
        i_start = 1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk); #1;
            if (n == 1) begin
                i_start = 0;
                fetch_ok = o_busy && o_section == 2'd0 && !o_rb_read_enable && !o_mem_data_read_enable;
            end
            if (n == 2) i_pc_value = ~pc_m;
            if (o_tx_start) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        bit to = 1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk); #1;
            if (!o_busy) begin
                to = 0;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(to), 32'd0);
    endtask

    task automatic check_full(input string tag);
        check({tag, "_count"},   rx_q.size(), 260);
        check({tag, "_done"},    done_count, 1);
        check({tag, "_stream"},  stream_errors(260), 0);
        check({tag, "_reads"},   read_err, 0);
        check({tag, "_stable"},  tx_unstable, 0);
        check({tag, "_proto"},   proto_err, 0);
    endtask

    initial begin
        int lat;
        bit fok, to;

        // Reset state, before any clock edge
        #1;
        check("rst_busy",    32'(o_busy), 0);
        check("rst_done",    32'(o_done), 0);
        check("rst_start",   32'(o_tx_start), 0);
        check("rst_section", 32'(o_section), 3);
        check("rst_txdata",  32'(o_tx_data), 0);
        check("rst_rbaddr",  32'(o_rb_addr), 0);
        check("rst_memaddr", 32'(o_mem_data_addr), 0);
        check("rst_enables", 32'({o_rb_enable, o_rb_read_enable, o_mem_data_enable, o_mem_data_read_enable}), 0);
        repeat (3) @(negedge clk);
        rst = 0;

        // Directed dump with known contents, tx_done 10 cycles after each start
        pc_m = 32'h00400010;
        for (int k = 0; k < 32; k++) begin
            rb_m[k]  = k * 32'h01010101;
            mem_m[k] = 32'hA0000000 + k;
        end
        lat_cfg = 10;
        build_expected();
        clear_counters();
        start_dump(lat, fok);
        check("latency", lat, 3);
        check("pc_fetch_no_read", 32'(fok), 1);
        wait_idle("dump1");
        check("b0", rx_at(0), 8'h10);
        check("b1", rx_at(1), 8'h00);
        check("b2", rx_at(2), 8'h40);
        check("b3", rx_at(3), 8'h00);
        for (int i = 128; i < 132; i++) check("rb31_byte", rx_at(i), 8'h1F);
        check("last0", rx_at(256), 8'h1F);
        check("last1", rx_at(257), 8'h00);
        check("last2", rx_at(258), 8'h00);
        check("last3", rx_at(259), 8'hA0);
        check("section_trace", trace, 32'h1B);
        check("rb_reads", rb_reads, 32);
        check("mem_reads", mem_reads, 32);
        check_full("dump1");

        // Random contents and latencies, start pulsed while busy
        randomize_contents();
        lat_cfg = 0;
        build_expected();
        clear_counters();
        start_dump(lat, fok);
        to = 1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (rx_q.size() >= 5) begin
                to = 0;
                break;
            end
        end
        check("busy_start_wait", 32'(to), 0);
        i_start = 1;
        @(negedge clk); #1;
        i_start = 0;
        wait_idle("dump2");
        check_full("dump2");

        // Abort together with tx_done of byte 50
        randomize_contents();
        build_expected();
        clear_counters();
        abort_at = 50;
        start_dump(lat, fok);
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (i_abort) begin
                to = 0;
                break;
            end
        end
        check("abort_wait", 32'(to), 0);
        @(posedge clk); #1;
        check("abort_busy", 32'(o_busy), 0);
        check("abort_section", 32'(o_section), 3);
        check("abort_txstart", 32'(o_tx_start), 0);
        abort_at = 0;
        repeat (40) @(negedge clk);
        #1;
        check("abort_count", rx_q.size(), 50);
        check("abort_no_done", done_count, 0);
        check("abort_prefix", stream_errors(50), 0);

        // Restart after abort begins from the PC
        randomize_contents();
        build_expected();
        clear_counters();
        start_dump(lat, fok);
        check("restart_latency", lat, 3);
        wait_idle("dump3");
        check_full("dump3");

        // Asynchronous reset mid-cycle during RB[7]
        randomize_contents();
        build_expected();
        clear_counters();
        start_dump(lat, fok);
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (o_tx_start && rx_q.size() == 34) begin
                to = 0;
                break;
            end
        end
        check("reset_wait", 32'(to), 0);
        #1;
        rst = 1;
        #1;
        check("areset_busy", 32'(o_busy), 0);
        check("areset_txstart", 32'(o_tx_start), 0);
        check("areset_section", 32'(o_section), 3);
        check("areset_txdata", 32'(o_tx_data), 0);
        @(negedge clk); #1;
        rst = 0;
        repeat (5) @(negedge clk);
        #1;
        check("areset_no_done", done_count, 0);
        check("areset_count", rx_q.size(), 34);

        // First dump after reset release starts from the PC
        clear_counters();
        start_dump(lat, fok);
        wait_idle("dump4");
        check_full("dump4");
        check("dump4_trace", trace, 32'h1B);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
